fifo_uart_tx: RTL and testbench

Downstream consumer of the 64x8 byte FIFO. It pops bytes through the FIFO read port and serialises each byte as an asynchronous UART frame on a single line: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. It is the transmit back-end of the byte path. It honours the FIFO's registered read, where data appears on the FIFO output one clock after the pop.

---
 rtl/fifo_uart_tx.sv | 149 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the 64x8 FIFO (registered read) and sends each
// one as a UART frame: start bit, 8 data bits LSB first, optional parity bit,
// then 1 or 2 stop bits. All outputs are registered.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        rd_en,
    output logic        tx,
    output logic        busy,
    output logic        tx_done,
    output logic [15:0] frame_count
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             bit_end;

    assign bit_end = (baud_cnt == CNT_LAST);

    // Parity bit value: even parity is the XOR of the data bits, odd inverts it.
    function automatic logic parity_of(input logic [7:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    // Frame sequencer. tx is registered, so each state's line level is loaded
    // on the edge that enters that state; rd_en and tx_done default to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            rd_en       <= 1'b0;
            tx          <= 1'b1;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            frame_count <= '0;
        end else begin
            rd_en   <= 1'b0;
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    // fifo_empty is trusted only here; as sole reader nobody
                    // else can drain the FIFO before the pop lands.
                    if (enable && !fifo_empty) begin
                        state <= FETCH;
                        rd_en <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    // Pop happens at the end of this cycle; data shows up next.
                    state <= LOAD;
                end
                LOAD: begin
                    shift_reg <= fifo_data;
                    baud_cnt  <= '0;
                    tx        <= 1'b0;
                    state     <= START;
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                tx    <= parity_of(shift_reg);
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift_reg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // bit_idx counts stop bits here.
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx     <= '0;
                            tx_done     <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (plain 8N1, odd parity + 2 stop,
// even parity + 2 stop) each fed by a behavioural registered-read FIFO; every
// frame is compared cycle by cycle against the bit list built from the byte.
module tb_fifo_uart_tx;

    logic              clk;
    logic              rst;
    logic [2:0]        enable;
    logic [2:0]        fifo_empty;
    logic [2:0][7:0]   fifo_data;
    logic [2:0]        rd_en;
    logic [2:0]        tx;
    logic [2:0]        busy;
    logic [2:0]        tx_done;
    logic [2:0][15:0]  frame_count;

    int tests = 0;
    int fails = 0;

    int cpb   [3];
    int pen   [3];
    int podd  [3];
    int nstop [3];
    int exp_count [3];
    int exp_pops  [3];

    logic [7:0] mem [3][64];
    int wp [3];
    int rp [3];
    int rd_cnt [3];
    int bad_pop [3];

    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .enable(enable[0]), .fifo_empty(fifo_empty[0]),
        .fifo_data(fifo_data[0]), .rd_en(rd_en[0]), .tx(tx[0]), .busy(busy[0]),
        .tx_done(tx_done[0]), .frame_count(frame_count[0])
    );

    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .enable(enable[1]), .fifo_empty(fifo_empty[1]),
        .fifo_data(fifo_data[1]), .rd_en(rd_en[1]), .tx(tx[1]), .busy(busy[1]),
        .tx_done(tx_done[1]), .frame_count(frame_count[1])
    );

    fifo_uart_tx #(.CLKS_PER_BIT(3), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .enable(enable[2]), .fifo_empty(fifo_empty[2]),
        .fifo_data(fifo_data[2]), .rd_en(rd_en[2]), .tx(tx[2]), .busy(busy[2]),
        .tx_done(tx_done[2]), .frame_count(frame_count[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: empty flag from pointers, data registered one clock after pop.
    always_comb begin
        for (int d = 0; d < 3; d++) fifo_empty[d] = (wp[d] == rp[d]);
    end

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rd_en[d]) begin
                rd_cnt[d] <= rd_cnt[d] + 1;
                if (wp[d] != rp[d]) begin
                    fifo_data[d] <= mem[d][rp[d] % 64];
                    rp[d]        <= rp[d] + 1;
                end else begin
                    bad_pop[d] <= bad_pop[d] + 1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int d, input logic [7:0] b);
        mem[d][wp[d] % 64] = b;
        wp[d] = wp[d] + 1;
    endtask

    // Waits for the pop, then checks the LOAD cycle, every cycle of every
    // frame bit, and the tx_done/frame_count cycle. act=1 drops enable during
    // data bit 1; act=2 pulses reset during data bit 3 and stops there.
    task automatic check_frame(input int d, input logic [7:0] b, input int exp_wait, input int act);
        int   n;
        logic bits [$];
        n = 0;
        while (rd_en[d] !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("rd_en_seen%0d", d), 32'(rd_en[d]), 32'd1);
        if (rd_en[d] !== 1'b1) return;
        exp_pops[d]++;
        if (exp_wait >= 0) chk($sformatf("rd_en_latency%0d", d), n, exp_wait);
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (pen[d] != 0) bits.push_back((^b) ^ (podd[d] != 0));
        for (int s = 0; s < nstop[d]; s++) bits.push_back(1'b1);
        @(negedge clk);
        chk($sformatf("load_cycle%0d", d), {tx[d], rd_en[d], busy[d]}, 3'b101);
        for (int i = 0; i < bits.size(); i++) begin
            for (int c = 0; c < cpb[d]; c++) begin
                @(negedge clk);
                chk($sformatf("d%0d_bit%0d", d, i), {tx[d], rd_en[d], busy[d]}, {bits[i], 2'b01});
                if (act == 1 && i == 2 && c == 0) enable[d] = 1'b0;
                if (act == 2 && i == 4 && c == 1) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    chk("reset_mid_frame", {tx[d], rd_en[d], busy[d], tx_done[d]}, 4'b1000);
                    chk("reset_count", 32'(frame_count[d]), 32'd0);
                    for (int e = 0; e < 3; e++) exp_count[e] = 0;
                    return;
                end
            end
        end
        @(negedge clk);
        exp_count[d]++;
        chk($sformatf("frame_end%0d", d), {tx[d], busy[d], tx_done[d]}, 3'b101);
        chk($sformatf("frame_count%0d", d), 32'(frame_count[d]), 32'(exp_count[d]));
    endtask

    initial begin
        logic [7:0] rb [$];
        int         r;
        cpb   = '{4, 4, 3};
        pen   = '{0, 1, 1};
        podd  = '{0, 1, 0};
        nstop = '{1, 2, 2};
        for (int d = 0; d < 3; d++) begin
            exp_count[d] = 0; exp_pops[d] = 0;
            wp[d] = 0; rp[d] = 0; rd_cnt[d] = 0; bad_pop[d] = 0;
        end
        rst    = 1'b1;
        enable = 3'b111;

        // Reset with empty FIFOs and enable high
        repeat (3) begin
            @(negedge clk);
            chk("reset_tx", 32'(tx), 32'h7);
            chk("reset_rd_en", 32'(rd_en), 32'h0);
            chk("reset_busy", 32'(busy), 32'h0);
            chk("reset_done_count", {tx_done, frame_count[0], 13'd0}, 32'd0);
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("idle_empty", {tx, rd_en, busy}, 9'b111_000_000);
        end

        // Single 0x55 frame
        push(0, 8'h55);
        check_frame(0, 8'h55, -1, 0);
        chk("pops_single", rd_cnt[0], exp_pops[0]);

        // Back-to-back 0xA3, 0x0F: exactly 3 high cycles between frames
        push(0, 8'hA3);
        push(0, 8'h0F);
        check_frame(0, 8'hA3, -1, 0);
        check_frame(0, 8'h0F, 1, 0);
        chk("pops_b2b", rd_cnt[0], exp_pops[0]);

        // Parity with 2 stop bits: odd on dut1, even on dut2
        push(1, 8'h07);
        check_frame(1, 8'h07, -1, 0);
        push(2, 8'h07);
        check_frame(2, 8'h07, -1, 0);

        // Random bursts on every instance
        for (int it = 0; it < 3; it++) begin
            for (int d = 0; d < 3; d++) begin
                rb = {};
                r  = $urandom_range(1, 3);
                for (int k = 0; k < r; k++) begin
                    rb.push_back(8'($urandom_range(0, 255)));
                    push(d, rb[k]);
                end
                for (int k = 0; k < r; k++) check_frame(d, rb[k], (k == 0) ? -1 : 1, 0);
                chk($sformatf("pops_rand%0d", d), rd_cnt[d], exp_pops[d]);
            end
        end

        // enable dropped mid-frame: frame finishes, then no pop until re-enabled
        rb = {};
        rb.push_back(8'($urandom_range(0, 255)));
        rb.push_back(8'($urandom_range(0, 255)));
        push(0, rb[0]);
        push(0, rb[1]);
        check_frame(0, rb[0], -1, 1);
        repeat (20) @(negedge clk);
        chk("hold_no_pop", rd_cnt[0], exp_pops[0]);
        chk("hold_idle", {tx[0], busy[0]}, 2'b10);
        enable[0] = 1'b1;
        check_frame(0, rb[1], 1, 0);

        // Reset mid-frame: popped byte is lost, next queued byte goes out
        push(0, 8'hC6);
        push(0, 8'h39);
        check_frame(0, 8'hC6, -1, 2);
        check_frame(0, 8'h39, 1, 0);
        chk("pops_after_reset", rd_cnt[0], exp_pops[0]);

        for (int d = 0; d < 3; d++) begin
            chk($sformatf("no_pop_when_empty%0d", d), bad_pop[d], 0);
            chk($sformatf("fifo_drained%0d", d), rp[d], wp[d]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
